// File: rtl/alu_pkg.sv
// Shared opcode constants, FSM state type and default width
// for the multi-cycle execute-stage ALU.
package alu_pkg;

    localparam int ALU_WIDTH = 32;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_SLTU = 4'b1100;
    localparam logic [3:0] ALU_SLL  = 4'b1000;
    localparam logic [3:0] ALU_SRL  = 4'b1001;
    localparam logic [3:0] ALU_XOR  = 4'b1010;
    localparam logic [3:0] ALU_SRA  = 4'b1011;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/alu_shift_step.sv
// Single-bit shift of a WIDTH-bit word; left, logical right
// or arithmetic right depending on the select inputs.
module alu_shift_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] data,
    input  logic             left,
    input  logic             arith,
    output logic [WIDTH-1:0] out
);

    always_comb begin
        if (left) begin
            out = {data[WIDTH-2:0], 1'b0};
        end else begin
            out = {arith & data[WIDTH-1], data[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/alu_sequential.sv
// Multi-cycle integer ALU: one-cycle logic/arithmetic, shifts
// iterated one bit per cycle through alu_shift_step.
module alu_sequential
    import alu_pkg::*;
#(
    parameter int WIDTH   = ALU_WIDTH,
    parameter int SHAMT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       aluop,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero
);

    state_t state;
    state_t state_next;

    logic               accept;
    logic               is_shift;
    logic               shift_now;
    logic               last_step;
    logic [SHAMT_W-1:0] amt;
    logic [SHAMT_W-1:0] count;
    logic [WIDTH-1:0]   sh_reg;
    logic [WIDTH-1:0]   step_out;
    logic [WIDTH-1:0]   alu_out;
    logic               sh_left;
    logic               sh_arith;

    assign amt       = operand_b[SHAMT_W-1:0];
    assign accept    = start && (state == IDLE);
    assign is_shift  = (aluop == ALU_SLL) || (aluop == ALU_SRL)
                    || (aluop == ALU_SRA);
    assign shift_now = accept && is_shift && (amt != '0);
    assign last_step = (state == SHIFT) && (count == SHAMT_W'(1));

    // Shift ops only reach this path with a zero amount.
    always_comb begin
        alu_out = operand_a + operand_b;
        case (aluop)
            ALU_AND:  alu_out = operand_a & operand_b;
            ALU_OR:   alu_out = operand_a | operand_b;
            ALU_XOR:  alu_out = operand_a ^ operand_b;
            ALU_SUB:  alu_out = operand_a - operand_b;
            ALU_SLT:  alu_out = {{(WIDTH-1){1'b0}},
                                 $signed(operand_a) < $signed(operand_b)};
            ALU_SLTU: alu_out = {{(WIDTH-1){1'b0}}, operand_a < operand_b};
            ALU_SLL,
            ALU_SRL,
            ALU_SRA:  alu_out = operand_a;
            default:  alu_out = operand_a + operand_b;
        endcase
    end

    alu_shift_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .data  (sh_reg),
        .left  (sh_left),
        .arith (sh_arith),
        .out   (step_out)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (shift_now) state_next = SHIFT;
            SHIFT:   if (last_step) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == SHIFT);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result   <= '0;
            zero     <= 1'b0;
            done     <= 1'b0;
            count    <= '0;
            sh_reg   <= '0;
            sh_left  <= 1'b0;
            sh_arith <= 1'b0;
        end else begin
            done <= 1'b0;
            if (shift_now) begin
                sh_reg   <= operand_a;
                count    <= amt;
                sh_left  <= (aluop == ALU_SLL);
                sh_arith <= (aluop == ALU_SRA);
            end else if (accept) begin
                result <= alu_out;
                zero   <= (alu_out == '0);
                done   <= 1'b1;
            end else if (state == SHIFT) begin
                sh_reg <= step_out;
                count  <= count - 1'b1;
                if (last_step) begin
                    result <= step_out;
                    zero   <= (step_out == '0);
                    done   <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_sequential.sv
// Directed plus random bench for alu_sequential against an
// arithmetic reference model.
module tb_alu_sequential;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  aluop;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        zero;

    int errors = 0;
    int checks = 0;

    alu_sequential #(
        .WIDTH   (32),
        .SHAMT_W (5)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .aluop     (aluop),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_alu(input logic [3:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        int n;
        n = int'(b[4:0]);
        case (op)
            4'b0000: return a & b;
            4'b0001: return a | b;
            4'b1010: return a ^ b;
            4'b0110: return a - b;
            4'b0111: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'b1100: return (a < b) ? 32'd1 : 32'd0;
            4'b1000: return a << n;
            4'b1001: return a >> n;
            4'b1011: return $unsigned($signed(a) >>> n);
            default: return a + b;
        endcase
    endfunction

    function automatic int ref_lat(input logic [3:0] op,
                                   input logic [31:0] b);
        if ((op == 4'b1000 || op == 4'b1001 || op == 4'b1011)
            && b[4:0] != 5'd0)
            return int'(b[4:0]) + 1;
        return 1;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input string tag);
        logic [31:0] exp_r;
        int exp_l;
        int lat;
        int bcnt;
        exp_r = ref_alu(op, a, b);
        exp_l = ref_lat(op, b);
        @(negedge clk);
        start = 1'b1;
        aluop = op;
        operand_a = a;
        operand_b = b;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        bcnt = 0;
        while (!done && lat < 100) begin
            if (busy) bcnt++;
            @(negedge clk);
            lat++;
        end
        check({tag, "_lat"}, 32'(lat), 32'(exp_l));
        check({tag, "_busy"}, 32'(bcnt), 32'(exp_l - 1));
        check({tag, "_res"}, result, exp_r);
        check({tag, "_zero"}, {31'd0, zero}, {31'd0, exp_r == 32'd0});
    endtask

    initial begin
        logic [3:0] ops [11];
        logic [31:0] held;
        int lat;
        int seen;
        ops = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100,
                4'b1000, 4'b1001, 4'b1011, 4'b1010, 4'b0101};
        reset = 1'b1;
        start = 1'b0;
        aluop = 4'b0;
        operand_a = '0;
        operand_b = '0;
        repeat (3) @(negedge clk);
        check("rst_result", result, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_zero", {31'd0, zero}, 32'd0);
        reset = 1'b0;

        run_op(4'b0010, 32'h7FFF_FFFF, 32'd1, "add_ovf");
        run_op(4'b0110, 32'd5, 32'd5, "sub_zero");
        run_op(4'b0111, 32'hFFFF_FFFF, 32'd1, "slt");
        run_op(4'b1100, 32'hFFFF_FFFF, 32'd1, "sltu");
        run_op(4'b0101, 32'd3, 32'd4, "unk_op");
        check("unk_val", result, 32'd7);
        run_op(4'b1000, 32'd1, 32'd31, "sll31");
        check("sll31_val", result, 32'h8000_0000);
        run_op(4'b1011, 32'h8000_0000, 32'd4, "sra4");
        check("sra4_val", result, 32'hF800_0000);
        run_op(4'b1001, 32'hDEAD_BEEF, 32'h20, "shift0");

        // start during SHIFT must be ignored
        @(negedge clk);
        start = 1'b1;
        aluop = 4'b1000;
        operand_a = 32'd3;
        operand_b = 32'd8;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1;
        aluop = 4'b0010;
        operand_a = 32'd1;
        operand_b = 32'd1;
        @(negedge clk);
        start = 1'b0;
        lat = 3;
        while (!done && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check("ign_lat", 32'(lat), 32'd9);
        check("ign_res", result, 32'h0000_0300);
        held = result;
        @(negedge clk);
        check("ign_nodone", {31'd0, done}, 32'd0);
        check("ign_held", result, held);

        // reset in the third cycle of srl by 10
        @(negedge clk);
        start = 1'b1;
        aluop = 4'b1001;
        operand_a = 32'hFFFF_0000;
        operand_b = 32'd10;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("mid_busy_pre", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        #1;
        check("mid_result", result, 32'd0);
        check("mid_busy", {31'd0, busy}, 32'd0);
        check("mid_done", {31'd0, done}, 32'd0);
        check("mid_zero", {31'd0, zero}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (done) seen++;
        end
        check("mid_never_done", 32'(seen), 32'd0);
        run_op(4'b0010, 32'd100, 32'd23, "post_rst_add");

        // back-to-back single-cycle ops
        @(negedge clk);
        start = 1'b1;
        aluop = 4'b0000;
        operand_a = 32'h0000_F0F0;
        operand_b = 32'h0000_0FF0;
        @(negedge clk);
        check("b2b_and_done", {31'd0, done}, 32'd1);
        check("b2b_and", result, 32'h0000_00F0);
        aluop = 4'b0001;
        @(negedge clk);
        check("b2b_or_done", {31'd0, done}, 32'd1);
        check("b2b_or", result, 32'h0000_FFF0);
        aluop = 4'b1010;
        @(negedge clk);
        check("b2b_xor_done", {31'd0, done}, 32'd1);
        check("b2b_xor", result, 32'h0000_FF00);
        start = 1'b0;
        @(negedge clk);
        check("b2b_end", {31'd0, done}, 32'd0);

        for (int i = 0; i < 40; i++) begin
            logic [3:0] op;
            logic [31:0] a;
            logic [31:0] b;
            op = ops[$urandom_range(0, 10)];
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? a : $urandom;
            run_op(op, a, b, $sformatf("rnd%0d_op%h", i, op));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
